// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte-stream requesters.
// A grant is held for a whole frame, and stalls on either side are recovered by timeouts.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ACK_TIMEOUT = 1024,
  parameter int GAP_TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           uart_tx_data,
  output logic                 uart_tx_write_en,
  output logic                 uart_tx_en,
  input  logic                 uart_tx_ready,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [2:0]           state_dbg
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  state_t             state, state_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [IW-1:0]      owner, owner_d;
  logic [IW-1:0]      rr_ptr, rr_ptr_d;
  logic [IW-1:0]      pick_idx, next_ptr;
  logic               pick_found;
  logic [7:0]         data_d;
  logic               last_q, last_d;
  logic [AW-1:0]      ack_cnt;
  logic [GW-1:0]      gap_cnt;
  logic               own_valid, own_last;
  logic [7:0]         own_data;
  logic               ack_timeout, gap_timeout;

  // First valid requester at or above rr_ptr, otherwise the lowest valid one (wrap-around).
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && req_valid[i] && (IW'(i) >= rr_ptr)) begin
        pick_found = 1'b1;
        pick_idx   = IW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && req_valid[i]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    own_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) own_data = own_data | req_data[8*i +: 8];
    end
  end

  assign own_valid   = |(grant & req_valid);
  assign own_last    = |(grant & req_last);
  assign next_ptr    = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
  // The ack timeout fires on its count even if the UART answers in the same cycle.
  assign ack_timeout = (state == ST_WAIT_BUSY) && (ack_cnt == AW'(ACK_TIMEOUT - 1));
  assign gap_timeout = (state == ST_LOAD) && !own_valid && (gap_cnt == GW'(GAP_TIMEOUT - 1));

  // Handshake: a requester holds req_valid/req_data/req_last stable until it sees
  // req_ready high on a clock edge; that edge transfers the byte, and the requester
  // may then present its next byte (or drop req_valid) from the following cycle.
  always_comb begin
    state_d  = state;
    grant_d  = grant;
    owner_d  = owner;
    rr_ptr_d = rr_ptr;
    data_d   = uart_tx_data;
    last_d   = last_q;
    case (state)
      ST_IDLE: begin
        if (pick_found && uart_tx_ready) begin
          for (int i = 0; i < NUM_REQ; i++) grant_d[i] = (pick_idx == IW'(i));
          owner_d = pick_idx;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (gap_timeout) begin
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          state_d  = ST_IDLE;
        end else if (own_valid) begin
          data_d  = own_data;
          last_d  = own_last;
          state_d = ST_SEND;
        end
      end
      ST_SEND: state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (ack_timeout) begin
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          state_d  = ST_IDLE;
        end else if (!uart_tx_ready) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (uart_tx_ready) begin
          if (last_q) begin
            grant_d  = '0;
            rr_ptr_d = next_ptr;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      grant        <= '0;
      owner        <= '0;
      rr_ptr       <= '0;
      uart_tx_data <= '0;
      last_q       <= 1'b0;
      ack_cnt      <= '0;
      gap_cnt      <= '0;
    end else begin
      state        <= state_d;
      grant        <= grant_d;
      owner        <= owner_d;
      rr_ptr       <= rr_ptr_d;
      uart_tx_data <= data_d;
      last_q       <= last_d;
      if (state != ST_WAIT_BUSY) ack_cnt <= '0;
      else if (ack_cnt != AW'(ACK_TIMEOUT)) ack_cnt <= ack_cnt + AW'(1);
      if (state != ST_LOAD) gap_cnt <= '0;
      else if (!own_valid && (gap_cnt != GW'(GAP_TIMEOUT))) gap_cnt <= gap_cnt + GW'(1);
    end
  end

  assign req_ready        = (state == ST_LOAD) ? (grant & req_valid) : '0;
  assign uart_tx_write_en = (state == ST_SEND);
  assign uart_tx_en       = (state == ST_SEND);
  assign busy             = (state != ST_IDLE);
  assign timeout_err      = ack_timeout | gap_timeout;
  assign state_dbg        = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-backed requesters, a simple UART model
// (busy 10 cycles per byte, or stuck) and immediate-assertion checks with hand-computed values.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ACK_T   = 16;
  localparam int GAP_T   = 20;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   req_valid, req_last, req_ready, grant;
  logic [23:0]  req_data;
  logic [7:0]   uart_tx_data;
  logic         uart_tx_write_en, uart_tx_en;
  logic         uart_tx_ready = 1'b1;
  logic         busy, timeout_err;
  logic [2:0]   state_dbg;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ACK_TIMEOUT(ACK_T), .GAP_TIMEOUT(GAP_T)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .grant(grant), .uart_tx_data(uart_tx_data), .uart_tx_write_en(uart_tx_write_en),
    .uart_tx_en(uart_tx_en), .uart_tx_ready(uart_tx_ready),
    .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int uart_cnt = 0;
  bit uart_stuck = 1'b0;
  logic [8:0] src0_q[$], src1_q[$], src2_q[$];
  logic [7:0] obs_q[$];
  int         obs_t_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Requester sources and invariants, updated away from the active edge.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("nonowner ready", {29'd0, req_ready & ~grant}, 32'd0);
      check("we/en coincident", {31'd0, uart_tx_write_en}, {31'd0, uart_tx_en});
    end
    if (src0_q.size() > 0) begin req_valid[0] = 1'b1; req_data[7:0] = src0_q[0][7:0]; req_last[0] = src0_q[0][8]; end
    else begin req_valid[0] = 1'b0; req_data[7:0] = 8'h00; req_last[0] = 1'b0; end
    if (src1_q.size() > 0) begin req_valid[1] = 1'b1; req_data[15:8] = src1_q[0][7:0]; req_last[1] = src1_q[0][8]; end
    else begin req_valid[1] = 1'b0; req_data[15:8] = 8'h00; req_last[1] = 1'b0; end
    if (src2_q.size() > 0) begin req_valid[2] = 1'b1; req_data[23:16] = src2_q[0][7:0]; req_last[2] = src2_q[0][8]; end
    else begin req_valid[2] = 1'b0; req_data[23:16] = 8'h00; req_last[2] = 1'b0; end
  end

  // Accept pops, strobe capture and UART model.
  always @(posedge clk) begin
    cyc++;
    if (req_ready[0] === 1'b1 && src0_q.size() > 0) src0_q.delete(0);
    if (req_ready[1] === 1'b1 && src1_q.size() > 0) src1_q.delete(0);
    if (req_ready[2] === 1'b1 && src2_q.size() > 0) src2_q.delete(0);
    if (uart_tx_write_en === 1'b1) begin
      obs_q.push_back(uart_tx_data);
      obs_t_q.push_back(cyc);
    end
    if (uart_tx_write_en === 1'b1 && !uart_stuck) begin
      uart_tx_ready <= 1'b0;
      uart_cnt      <= 10;
    end else if (!uart_tx_ready) begin
      if (uart_cnt <= 1) uart_tx_ready <= 1'b1;
      else uart_cnt <= uart_cnt - 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src0_q.delete(); src1_q.delete(); src2_q.delete();
    step(); step();
    reset = 1'b0;
    obs_q.delete(); obs_t_q.delete();
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    while (uart_tx_write_en !== 1'b1 && n < 200) begin step(); n++; end
    check({tag, " strobe seen"}, {31'd0, uart_tx_write_en}, 32'd1);
  endtask

  task automatic wait_obs(input string tag, input int cnt);
    int n = 0;
    while (obs_q.size() < cnt && n < 400) begin step(); n++; end
    check({tag, " byte count"}, obs_q.size(), cnt);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin step(); n++; end
    check({tag, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic compare_bytes(input string tag);
    check({tag, " total"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) check({tag, " order"}, {24'd0, obs_q[i]}, {24'd0, exp_q[i]});
    end
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, zero;
    reset = 1'b1;
    step(); step(); step();
    reset = 1'b0;

    // Reset state
    check("rst grant", {29'd0, grant}, 0);
    check("rst req_ready", {29'd0, req_ready}, 0);
    check("rst data", {24'd0, uart_tx_data}, 0);
    check("rst write_en", {31'd0, uart_tx_write_en}, 0);
    check("rst tx_en", {31'd0, uart_tx_en}, 0);
    check("rst busy", {31'd0, busy}, 0);
    check("rst timeout", {31'd0, timeout_err}, 0);
    check("rst state", {29'd0, state_dbg}, 0);

    // 1: three-byte frame from req0
    src0_q.push_back({1'b0, 8'hA1}); src0_q.push_back({1'b0, 8'hA2}); src0_q.push_back({1'b1, 8'hA3});
    step();
    check("t1 grant latency", {29'd0, grant}, 32'd1);
    check("t1 req_ready", {29'd0, req_ready}, 32'd1);
    check("t1 state load", {29'd0, state_dbg}, 32'd1);
    step();
    check("t1 write_en", {31'd0, uart_tx_write_en}, 1);
    check("t1 tx_en", {31'd0, uart_tx_en}, 1);
    check("t1 first data", {24'd0, uart_tx_data}, 32'hA1);
    k = 0;
    while (busy === 1'b1 && k < 400) begin
      check("t1 grant held", {29'd0, grant}, 32'd1);
      step(); k++;
    end
    check("t1 idle", {31'd0, busy}, 0);
    check("t1 grant released", {29'd0, grant}, 0);
    check("t1 data hold", {24'd0, uart_tx_data}, 32'hA3);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
    compare_bytes("t1 bytes");
    if (obs_t_q.size() == 3) begin
      check("t1 spacing a", obs_t_q[1] - obs_t_q[0], 13);
      check("t1 spacing b", obs_t_q[2] - obs_t_q[1], 13);
    end

    // 2: round-robin between req0 and req2
    do_reset();
    src0_q.push_back({1'b1, 8'hB0}); src0_q.push_back({1'b1, 8'hB1});
    src2_q.push_back({1'b1, 8'hC0});
    step();
    check("t2 first grant", {29'd0, grant}, 32'd1);
    k = 0;
    while (grant === 3'b001 && k < 100) begin step(); k++; end
    check("t2 release gap", {29'd0, grant}, 0);
    step();
    check("t2 req2 wins", {29'd0, grant}, 32'd4);
    wait_obs("t2", 3);
    wait_idle("t2");
    exp_q.push_back(8'hB0); exp_q.push_back(8'hC0); exp_q.push_back(8'hB1);
    compare_bytes("t2 bytes");

    // 3: req1 arrives mid-frame, no preemption
    do_reset();
    src0_q.push_back({1'b0, 8'hD0}); src0_q.push_back({1'b1, 8'hD1});
    wait_strobe("t3");
    src1_q.push_back({1'b1, 8'hE0});
    k = 0; zero = 0;
    while (grant !== 3'b010 && k < 300) begin
      step(); k++;
      if (grant === 3'b000) zero++;
    end
    check("t3 grant1", {29'd0, grant}, 32'd2);
    check("t3 gap cycles", zero, 1);
    check("t3 req1 ready", {29'd0, req_ready}, 32'd2);
    check("t3 bytes before grant1", obs_q.size(), 2);
    wait_obs("t3", 3);
    wait_idle("t3");
    exp_q.push_back(8'hD0); exp_q.push_back(8'hD1); exp_q.push_back(8'hE0);
    compare_bytes("t3 bytes");

    // 4: UART never acknowledges
    do_reset();
    uart_stuck = 1'b1;
    src0_q.push_back({1'b1, 8'hF0});
    wait_strobe("t4");
    k = 0;
    while (timeout_err !== 1'b1 && k < 200) begin step(); k++; end
    check("t4 ack timeout cycles", k, ACK_T);
    step();
    check("t4 pulse width", {31'd0, timeout_err}, 0);
    check("t4 grant cleared", {29'd0, grant}, 0);
    check("t4 busy", {31'd0, busy}, 0);
    uart_stuck = 1'b0;

    // 5: owner stalls mid-frame, req2 takes over
    do_reset();
    src0_q.push_back({1'b0, 8'h51});
    wait_strobe("t5");
    src2_q.push_back({1'b1, 8'h52});
    k = 0;
    while (timeout_err !== 1'b1 && k < 200) begin step(); k++; end
    check("t5 gap timeout cycles", k, 31);
    check("t5 no accept", {29'd0, req_ready}, 0);
    step();
    check("t5 pulse width", {31'd0, timeout_err}, 0);
    check("t5 grant cleared", {29'd0, grant}, 0);
    step();
    check("t5 req2 granted", {29'd0, grant}, 32'd4);
    wait_obs("t5", 2);
    wait_idle("t5");
    exp_q.push_back(8'h51); exp_q.push_back(8'h52);
    compare_bytes("t5 bytes");

    // 6: reset during WAIT_DONE
    do_reset();
    src0_q.push_back({1'b0, 8'h61}); src0_q.push_back({1'b1, 8'h62});
    wait_strobe("t6");
    step(); step();
    check("t6 in wait_done", {29'd0, state_dbg}, 32'd4);
    reset = 1'b1;
    src0_q.delete(); src1_q.delete(); src2_q.delete();
    step();
    check("t6 grant", {29'd0, grant}, 0);
    check("t6 req_ready", {29'd0, req_ready}, 0);
    check("t6 data", {24'd0, uart_tx_data}, 0);
    check("t6 write_en", {31'd0, uart_tx_write_en}, 0);
    check("t6 tx_en", {31'd0, uart_tx_en}, 0);
    check("t6 busy", {31'd0, busy}, 0);
    check("t6 timeout", {31'd0, timeout_err}, 0);
    check("t6 state", {29'd0, state_dbg}, 0);
    step();
    reset = 1'b0;
    check("t6 bytes before reset", obs_q.size(), 1);
    repeat (25) step();
    check("t6 no strobes after reset", obs_q.size(), 1);
    src0_q.push_back({1'b1, 8'h63});
    src1_q.push_back({1'b1, 8'h64});
    step();
    check("t6 rr_ptr zero", {29'd0, grant}, 32'd1);
    wait_obs("t6", 3);
    wait_idle("t6");
    exp_q.push_back(8'h61); exp_q.push_back(8'h63); exp_q.push_back(8'h64);
    compare_bytes("t6 bytes");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
